reaction_seq_ctrl: RTL and testbench



---
 rtl/reaction_pkg.sv | 35 +++
 rtl/rt_lfsr16.sv | 43 ++++
 rtl/reaction_seq_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_reaction_seq_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// ---------------------------------------------------------------------------
// reaction_pkg
//
// Shared definitions for the reaction-timer trial sequencer:
//   - state_e           : sequencer states
//   - LFSR_TAPS         : Galois tap mask for x^16+x^14+x^13+x^11
//   - LFSR_SEED_DEFAULT : default non-zero LFSR reset value
//   - DLY_UNIT_MS       : period of one delay-unit count, in ms
//   - lfsr_next()       : one Galois LFSR step
// ---------------------------------------------------------------------------
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT,
        STIM,
        RESULT,
        FAULT
    } state_e;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // One count of the shared delay unit lasts this many milliseconds, so a
    // foreperiod of dly_value counts lasts dly_value * DLY_UNIT_MS ms.
    localparam int unsigned DLY_UNIT_MS = 10;

    // Galois form: shift right, and fold the tap mask in when a 1 leaves
    // through bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/rt_lfsr16.sv
// ---------------------------------------------------------------------------
// rt_lfsr16
//
// Free-running 16-bit Galois LFSR used to pick the foreperiod. It advances on
// every clock from reset release, so the value sampled when a trial starts
// depends on how long the player waited before pressing go.
//
// Parameters:
//   SEED     reset value; must be non-zero or the register locks at zero
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous, active-low reset (loads SEED)
//   q        out  current LFSR state
// ---------------------------------------------------------------------------
module rt_lfsr16
    import reaction_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);

    // NOTE: clocked state is written only with non-blocking assignments so
    // every register samples values from before the edge, whatever order the
    // simulator evaluates the blocks in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/reaction_seq_ctrl.sv
// ---------------------------------------------------------------------------
// reaction_seq_ctrl
//
// Trial sequencer for the reaction-timer game. On go it picks a pseudo-random
// foreperiod, runs the shared delay unit, lights the stimulus LED when the
// delay unit reports done, then counts milliseconds until the player reacts.
// A press before the stimulus aborts the trial as an early press.
//
// Parameters:
//   TICK_CYCLES  clk cycles per 1 ms reaction tick
//   DELAY_MIN    minimum foreperiod, in delay-unit counts
//   RT_MAX       reaction-time saturation value, in ms (trial times out)
//   LFSR_SEED    LFSR reset value, non-zero
//
// Ports:
//   clk         in   clock
//   reset_n     in   asynchronous, active-low reset
//   go          in   one-cycle pulse, starts a trial
//   react       in   one-cycle pulse, player response
//   dly_done    in   done flag from the delay unit
//   dly_start   out  load strobe to the delay unit
//   dly_enable  out  run enable to the delay unit
//   dly_value   out  foreperiod sent to the delay unit
//   led_stim    out  stimulus LED
//   rt_ms       out  measured reaction time in ms
//   rt_valid    out  rt_ms holds a finished result
//   early       out  trial aborted by an early press
//   busy        out  trial in progress (ARM, WAIT, STIM)
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module reaction_seq_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 50000,
    parameter logic [7:0]  DELAY_MIN   = 8'd50,
    parameter logic [15:0] RT_MAX      = 16'd9999,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic        react,
    input  logic        dly_done,
    output logic        dly_start,
    output logic        dly_enable,
    output logic [7:0]  dly_value,
    output logic        led_stim,
    output logic [15:0] rt_ms,
    output logic        rt_valid,
    output logic        early,
    output logic        busy
);

    // Prescaler width; a 1-cycle tick still needs a 1-bit counter.
    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

    // -----------------------------------------------------------------------
    // Foreperiod source
    // -----------------------------------------------------------------------
    logic [15:0] lfsr_q;
    logic [6:0]  lfsr_low;
    logic [8:0]  lfsr_high_unused;

    rt_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (lfsr_q)
    );

    // Only the low seven bits feed the foreperiod; the rest of the register
    // exists to give those bits a long sequence.
    assign {lfsr_high_unused, lfsr_low} = lfsr_q;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_e          state_q;
    logic [PW-1:0]   prescaler_q;
    logic [15:0]     rt_ms_q;
    logic [7:0]      dly_value_q;
    logic            dly_start_q;
    logic            dly_enable_q;
    logic            led_stim_q;
    logic            rt_valid_q;
    logic            early_q;
    logic            busy_q;

    // -----------------------------------------------------------------------
    // Next-value helpers
    // -----------------------------------------------------------------------
    logic            tick_wrap;
    logic [PW-1:0]   prescaler_d;
    logic [15:0]     rt_ms_d;
    logic [7:0]      dly_value_d;

    // NOTE: every signal written here is assigned on every pass through the
    // block, so no path leaves a value to be remembered and no latch appears.
    always_comb begin
        tick_wrap   = (prescaler_q == TICK_LAST);
        prescaler_d = tick_wrap ? '0 : prescaler_q + PW'(1);
        // rt_ms_q never passes RT_MAX, so the increment cannot wrap.
        rt_ms_d     = rt_ms_q + 16'd1;
        // Largest result is DELAY_MIN + 127, which fits for DELAY_MIN <= 128.
        dly_value_d = DELAY_MIN + {1'b0, lfsr_low};
    end

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            prescaler_q  <= '0;
            rt_ms_q      <= '0;
            dly_value_q  <= '0;
            dly_start_q  <= 1'b0;
            dly_enable_q <= 1'b0;
            led_stim_q   <= 1'b0;
            rt_valid_q   <= 1'b0;
            early_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                // Idle and both finished states wait for go; the last result
                // or early flag stays visible until then.
                IDLE, RESULT, FAULT: begin
                    if (go) begin
                        state_q     <= ARM;
                        dly_value_q <= dly_value_d;
                        rt_ms_q     <= '0;
                        rt_valid_q  <= 1'b0;
                        early_q     <= 1'b0;
                        dly_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end

                // One-cycle load strobe, then let the delay unit run.
                ARM: begin
                    state_q      <= WAIT;
                    dly_start_q  <= 1'b0;
                    dly_enable_q <= 1'b1;
                end

                // Foreperiod running. A press here is early, and it wins
                // over a done flag arriving in the same cycle.
                WAIT: begin
                    if (react) begin
                        state_q      <= FAULT;
                        early_q      <= 1'b1;
                        dly_enable_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else if (dly_done) begin
                        state_q      <= STIM;
                        led_stim_q   <= 1'b1;
                        dly_enable_q <= 1'b0;
                        prescaler_q  <= '0;
                        rt_ms_q      <= '0;
                    end
                end

                // Stimulus lit: count ms until the press or until RT_MAX.
                // On react the count is frozen as it stood before this
                // cycle, so a wrap in the react cycle is not counted.
                STIM: begin
                    if (react) begin
                        state_q    <= RESULT;
                        led_stim_q <= 1'b0;
                        rt_valid_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        prescaler_q <= prescaler_d;
                        if (tick_wrap) begin
                            rt_ms_q <= rt_ms_d;
                            if (rt_ms_d >= RT_MAX) begin
                                state_q    <= RESULT;
                                rt_ms_q    <= RT_MAX;
                                led_stim_q <= 1'b0;
                                rt_valid_q <= 1'b1;
                                busy_q     <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign dly_start  = dly_start_q;
    assign dly_enable = dly_enable_q;
    assign dly_value  = dly_value_q;
    assign led_stim   = led_stim_q;
    assign rt_ms      = rt_ms_q;
    assign rt_valid   = rt_valid_q;
    assign early      = early_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_reaction_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reaction_seq_ctrl
//
// Two sequencer instances share one clock and reset:
//   a : TICK_CYCLES=5, DELAY_MIN=2, RT_MAX=9999 (normal trials)
//   b : TICK_CYCLES=5, DELAY_MIN=2, RT_MAX=3    (saturation trials)
// Each has a behavioural delay unit (one count per clock) and a reference
// model that tracks a trial as a phase plus the index of the current STIM
// cycle, with the reaction time taken as floor(index / TICK_CYCLES).
// ---------------------------------------------------------------------------
module tb_reaction_seq_ctrl;

    localparam int          TICK       = 5;
    localparam int          DMIN       = 2;
    localparam int          RT_MAX_A   = 9999;
    localparam int          RT_MAX_B   = 3;
    localparam logic [15:0] SEED       = 16'hACE1;
    localparam int          TRIAL_BUDGET = 600;

    localparam int P_IDLE   = 0;
    localparam int P_ARM    = 1;
    localparam int P_WAIT   = 2;
    localparam int P_STIM   = 3;
    localparam int P_RESULT = 4;
    localparam int P_FAULT  = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        go         [2];
    logic        react      [2];
    logic        dly_done   [2];
    logic        dly_start  [2];
    logic        dly_enable [2];
    logic [7:0]  dly_value  [2];
    logic        led_stim   [2];
    logic [15:0] rt_ms      [2];
    logic        rt_valid   [2];
    logic        early      [2];
    logic        busy       [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, one slot per instance.
    int          m_ph    [2];
    int          m_k     [2];
    int          m_rt    [2];
    logic [15:0] m_lfsr  [2];
    logic [7:0]  m_dval  [2];
    bit          m_rtv   [2];
    bit          m_early [2];
    bit          m_led   [2];
    bit          m_start [2];
    bit          m_en    [2];
    bit          m_busy  [2];

    // Delay-unit model: remaining counts.
    int dcnt [2];

    always #5 clk = ~clk;

    reaction_seq_ctrl #(
        .TICK_CYCLES (TICK),
        .DELAY_MIN   (8'(DMIN)),
        .RT_MAX      (16'(RT_MAX_A)),
        .LFSR_SEED   (SEED)
    ) u_dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .go         (go[0]),
        .react      (react[0]),
        .dly_done   (dly_done[0]),
        .dly_start  (dly_start[0]),
        .dly_enable (dly_enable[0]),
        .dly_value  (dly_value[0]),
        .led_stim   (led_stim[0]),
        .rt_ms      (rt_ms[0]),
        .rt_valid   (rt_valid[0]),
        .early      (early[0]),
        .busy       (busy[0])
    );

    reaction_seq_ctrl #(
        .TICK_CYCLES (TICK),
        .DELAY_MIN   (8'(DMIN)),
        .RT_MAX      (16'(RT_MAX_B)),
        .LFSR_SEED   (SEED)
    ) u_dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .go         (go[1]),
        .react      (react[1]),
        .dly_done   (dly_done[1]),
        .dly_start  (dly_start[1]),
        .dly_enable (dly_enable[1]),
        .dly_value  (dly_value[1]),
        .led_stim   (led_stim[1]),
        .rt_ms      (rt_ms[1]),
        .rt_valid   (rt_valid[1]),
        .early      (early[1]),
        .busy       (busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic string pfx(input int u);
        return (u == 0) ? "a" : "b";
    endfunction

    function automatic int rt_max_of(input int u);
        return (u == 0) ? RT_MAX_A : RT_MAX_B;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_ph[u]    = P_IDLE;
            m_k[u]     = 0;
            m_rt[u]    = 0;
            m_lfsr[u]  = SEED;
            m_dval[u]  = 8'd0;
            m_rtv[u]   = 1'b0;
            m_early[u] = 1'b0;
            m_led[u]   = 1'b0;
            m_start[u] = 1'b0;
            m_en[u]    = 1'b0;
            m_busy[u]  = 1'b0;
            dcnt[u]    = 0;
            dly_done[u] = 1'b0;
        end
    endtask

    // One clock edge of the trial rules, given the inputs seen at that edge.
    task automatic model_step(input int u, input logic g, input logic r, input logic d);
        logic [15:0] l0;
        l0 = m_lfsr[u];
        m_lfsr[u] = {1'b0, l0[15:1]} ^ (l0[0] ? 16'hB400 : 16'h0000);
        case (m_ph[u])
            P_IDLE, P_RESULT, P_FAULT: begin
                if (g) begin
                    m_ph[u]    = P_ARM;
                    m_dval[u]  = 8'(DMIN + int'(l0[6:0]));
                    m_rt[u]    = 0;
                    m_rtv[u]   = 1'b0;
                    m_early[u] = 1'b0;
                    m_start[u] = 1'b1;
                    m_busy[u]  = 1'b1;
                end
            end
            P_ARM: begin
                m_ph[u]    = P_WAIT;
                m_start[u] = 1'b0;
                m_en[u]    = 1'b1;
            end
            P_WAIT: begin
                if (r) begin
                    m_ph[u]    = P_FAULT;
                    m_early[u] = 1'b1;
                    m_en[u]    = 1'b0;
                    m_busy[u]  = 1'b0;
                end else if (d) begin
                    m_ph[u]  = P_STIM;
                    m_led[u] = 1'b1;
                    m_en[u]  = 1'b0;
                    m_k[u]   = 0;
                    m_rt[u]  = 0;
                end
            end
            P_STIM: begin
                if (r) begin
                    m_ph[u]   = P_RESULT;
                    m_rtv[u]  = 1'b1;
                    m_led[u]  = 1'b0;
                    m_busy[u] = 1'b0;
                end else begin
                    m_k[u]++;
                    m_rt[u] = m_k[u] / TICK;
                    if (m_rt[u] >= rt_max_of(u)) begin
                        m_rt[u]   = rt_max_of(u);
                        m_ph[u]   = P_RESULT;
                        m_rtv[u]  = 1'b1;
                        m_led[u]  = 1'b0;
                        m_busy[u] = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        for (int u = 0; u < 2; u++) begin
            check({pfx(u), ".dly_start"},  dly_start[u],  m_start[u]);
            check({pfx(u), ".dly_enable"}, dly_enable[u], m_en[u]);
            check({pfx(u), ".dly_value"},  dly_value[u],  m_dval[u]);
            check({pfx(u), ".led_stim"},   led_stim[u],   m_led[u]);
            check({pfx(u), ".rt_ms"},      rt_ms[u],      m_rt[u]);
            check({pfx(u), ".rt_valid"},   rt_valid[u],   m_rtv[u]);
            check({pfx(u), ".early"},      early[u],      m_early[u]);
            check({pfx(u), ".busy"},       busy[u],       m_busy[u]);
        end
    endtask

    // Advance one clock: step the model at the edge, compare on the falling
    // edge, then drop the pulse inputs and let the delay units react.
    task automatic tick();
        @(posedge clk);
        if (reset_n) begin
            for (int u = 0; u < 2; u++) model_step(u, go[u], react[u], dly_done[u]);
        end
        @(negedge clk);
        compare_all();
        for (int u = 0; u < 2; u++) begin
            go[u]    = 1'b0;
            react[u] = 1'b0;
            if (dly_start[u]) begin
                dcnt[u]     = int'(dly_value[u]);
                dly_done[u] = 1'b0;
            end else if (dly_enable[u]) begin
                if (dcnt[u] <= 1) begin
                    dcnt[u]     = 0;
                    dly_done[u] = 1'b1;
                end else begin
                    dcnt[u]--;
                    dly_done[u] = 1'b0;
                end
            end else begin
                dly_done[u] = 1'b0;
            end
        end
    endtask

    // mode 0: react at STIM index `target`; 1: react in WAIT from cycle
    // `target` on; 2: react in the cycle dly_done is presented; 3: no react.
    task automatic run_trial(input int u, input int mode, input int target,
                             output logic [7:0] dval_seen, output bit led_seen);
        bit ended;
        ended    = 1'b0;
        led_seen = 1'b0;
        go[u]    = 1'b1;
        tick();
        dval_seen = dly_value[u];
        check({pfx(u), ".arm_start"}, dly_start[u], 1);
        check({pfx(u), ".arm_rt_ms"}, rt_ms[u], 0);
        check({pfx(u), ".arm_rt_valid"}, rt_valid[u], 0);
        check({pfx(u), ".arm_busy"}, busy[u], 1);
        for (int n = 0; n < TRIAL_BUDGET; n++) begin
            if (mode == 0 && m_ph[u] == P_STIM && m_k[u] == target) react[u] = 1'b1;
            if (mode == 1 && m_ph[u] == P_WAIT && (n >= target || dly_done[u])) react[u] = 1'b1;
            if (mode == 2 && m_ph[u] == P_WAIT && dly_done[u]) react[u] = 1'b1;
            if ((m_ph[u] == P_ARM || m_ph[u] == P_WAIT || m_ph[u] == P_STIM) &&
                $urandom_range(0, 9) == 0) go[u] = 1'b1;
            tick();
            if (led_stim[u]) led_seen = 1'b1;
            if (m_ph[u] == P_RESULT || m_ph[u] == P_FAULT) begin
                ended = 1'b1;
                break;
            end
        end
        check({pfx(u), ".trial_ends"}, ended, 1);
        // A few idle cycles holding the result.
        for (int n = $urandom_range(0, 3); n > 0; n--) tick();
    endtask

    initial begin
        logic [7:0] dval;
        bit         lit;
        bit         reached;

        reset_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            go[u]    = 1'b0;
            react[u] = 1'b0;
        end
        model_reset();

        // Reset held for three cycles: everything low.
        repeat (3) tick();
        check("rst_busy_a", busy[0], 0);
        check("rst_led_a", led_stim[0], 0);
        check("rst_start_b", dly_start[1], 0);

        // go on the first edge after release sees the seed: 2 + 0x61 = 99.
        reset_n = 1'b1;
        run_trial(0, 0, 23, dval, lit);
        check("first_dly_value", dval, 8'd99);
        check("rt_idx23", rt_ms[0], 4);
        check("rt_idx23_valid", rt_valid[0], 1);
        check("rt_idx23_led_off", led_stim[0], 0);
        check("rt_idx23_lit", lit, 1);

        // React exactly on the first wrap: the wrap is not counted.
        run_trial(0, 0, 4, dval, lit);
        check("rt_idx4", rt_ms[0], 0);
        check("rt_idx4_valid", rt_valid[0], 1);

        // Early press in WAIT.
        run_trial(0, 1, 1, dval, lit);
        check("early_flag", early[0], 1);
        check("early_rt_valid", rt_valid[0], 0);
        check("early_enable", dly_enable[0], 0);
        check("early_no_led", lit, 0);

        // Press and done together: early press wins.
        run_trial(0, 2, 0, dval, lit);
        check("tie_early", early[0], 1);
        check("tie_no_led", lit, 0);

        // Saturation: no press, times out at RT_MAX after 15 STIM cycles.
        run_trial(1, 3, 0, dval, lit);
        check("sat_rt_ms", rt_ms[1], RT_MAX_B);
        check("sat_rt_valid", rt_valid[1], 1);
        check("sat_led_off", led_stim[1], 0);

        // The next go clears the saturated result in its ARM cycle.
        run_trial(1, 0, 7, dval, lit);
        check("b_rt_idx7", rt_ms[1], 1);

        // Randomised trials on both instances.
        for (int t = 0; t < 20; t++) begin
            run_trial(0, int'($urandom_range(0, 2)), int'($urandom_range(0, 40)), dval, lit);
            check("rand_dval_range", (dval >= 8'(DMIN) && dval <= 8'(DMIN + 127)), 1);
        end
        for (int t = 0; t < 6; t++) begin
            run_trial(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 20)), dval, lit);
        end

        // Asynchronous reset in the middle of STIM.
        go[0] = 1'b1;
        reached = 1'b0;
        for (int n = 0; n < TRIAL_BUDGET; n++) begin
            tick();
            if (m_ph[0] == P_STIM && m_k[0] == 7) begin
                reached = 1'b1;
                break;
            end
        end
        check("mid_stim_reached", reached, 1);
        check("mid_stim_led", led_stim[0], 1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_led", led_stim[0], 0);
        check("async_rt_ms", rt_ms[0], 0);
        check("async_busy", busy[0], 0);
        check("async_enable", dly_enable[0], 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // A normal trial after the reset.
        run_trial(0, 0, 12, dval, lit);
        check("post_reset_rt", rt_ms[0], 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
